// File: rtl/led_tx_engine_pkg.sv
// Shared constants for the LED transmitter.
// Holds the FSM state encoding, the default WS2812 timing for a 50 MHz clk,
// and the number of bits in one GRB pixel.
package led_tx_engine_pkg;

    localparam int PIXEL_BITS = 24;

    // 400 ns / 800 ns high, 1.26 us period, 50 us latch gap at 50 MHz
    localparam int DEF_T0H    = 20;
    localparam int DEF_T1H    = 40;
    localparam int DEF_TBIT   = 63;
    localparam int DEF_TRESET = 2500;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

endpackage

// File: rtl/led_tx_engine_if.sv
// Wishbone read-master bus between led_tx_engine and the frame buffer.
// master: address/writedata/strobe/cycle/write out, readdata/ack in.
// slave : the mirror image.
interface led_tx_engine_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] wbm_address;
    logic [DATA_WIDTH-1:0] wbm_writedata;
    logic [DATA_WIDTH-1:0] wbm_readdata;
    logic                  wbm_strobe;
    logic                  wbm_cycle;
    logic                  wbm_write;
    logic                  wbm_ack;

    modport master (
        output wbm_address, wbm_writedata, wbm_strobe, wbm_cycle, wbm_write,
        input  wbm_readdata, wbm_ack
    );

    modport slave (
        input  wbm_address, wbm_writedata, wbm_strobe, wbm_cycle, wbm_write,
        output wbm_readdata, wbm_ack
    );
endinterface

// File: rtl/led_tx_engine_ws2812_bit_enc.sv
// One-bit NRZ encoder for WS2812-style LEDs.
// Ports: clk, reset (async, active-low); start loads bit_in and begins a
// TBIT-clock period; led_dout is high for T0H/T1H clocks from counter 0;
// bit_done pulses in the last clock of the period.  Asserting start in the
// bit_done cycle chains bits with no gap.
module ws2812_bit_enc #(
    parameter int T0H  = 20,
    parameter int T1H  = 40,
    parameter int TBIT = 63
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic bit_in,
    output logic led_dout,
    output logic bit_done
);
    localparam int            CW   = $clog2(TBIT);
    localparam logic [CW-1:0] LAST = CW'(TBIT - 1);
    localparam logic [CW-1:0] HI0  = CW'(T0H);
    localparam logic [CW-1:0] HI1  = CW'(T1H);

    logic [CW-1:0] cnt;
    logic          active;
    logic          bit_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            active <= 1'b0;
            bit_q  <= 1'b0;
        end else if (start) begin
            cnt    <= '0;
            active <= 1'b1;
            bit_q  <= bit_in;
        end else if (active) begin
            if (cnt == LAST) begin
                active <= 1'b0;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign led_dout = active && (cnt < (bit_q ? HI1 : HI0));
    assign bit_done = active && (cnt == LAST);

endmodule

// File: rtl/led_tx_engine.sv
// Serial LED frame transmitter.
// On a led_tx pulse, reads NLEDS GRB words starting at buf_id*NLEDS over
// Wishbone (one outstanding read, next pixel prefetched during bit 0 of the
// current one) and shifts them out MSB first on led_dout, then holds the line
// low for TRESET clocks and pulses led_tx_done.
// Ports: clk, reset (async, active-low), wb (Wishbone master modport),
// led_tx_buf_id/led_tx (start request), led_tx_done, led_dout.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | waiting for led_tx
//   ST_FETCH | reading pixel 0, line low
//   ST_SHIFT | sending bits; stall flag set while waiting on a late read
//   ST_LATCH | line low for TRESET clocks, then done pulse
module led_tx_engine
    import led_tx_engine_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NLEDS      = 64,
    parameter int T0H        = DEF_T0H,
    parameter int T1H        = DEF_T1H,
    parameter int TBIT       = DEF_TBIT,
    parameter int TRESET     = DEF_TRESET
) (
    input  logic                  clk,
    input  logic                  reset,
    led_tx_engine_if.master       wb,
    input  logic [DATA_WIDTH-1:0] led_tx_buf_id,
    input  logic                  led_tx,
    output logic                  led_tx_done,
    output logic                  led_dout
);
    localparam logic [ADDR_WIDTH-1:0] LAST_PIX   = ADDR_WIDTH'(NLEDS - 1);
    localparam logic [4:0]            LAST_BIT   = 5'(PIXEL_BITS - 1);
    localparam int                    LCW        = $clog2(TRESET + 1);
    localparam logic [LCW-1:0]        LATCH_LOAD = LCW'(TRESET - 1);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] pix_idx;
    logic [ADDR_WIDTH-1:0] address;
    logic [ADDR_WIDTH-1:0] new_base;
    logic                  cyc;
    logic [4:0]            bit_idx;
    logic [PIXEL_BITS-1:0] shift_reg;
    logic [PIXEL_BITS-1:0] hold_reg;
    logic [PIXEL_BITS-1:0] word;
    logic                  hold_valid;
    logic                  stall;
    logic                  done;
    logic [LCW-1:0]        latch_cnt;
    logic                  ack_now;
    logic                  last_pix;
    logic                  last_bit;
    logic                  load_word;
    logic                  enc_start;
    logic                  enc_bit;
    logic                  bit_done;
    logic                  unused_bits;

    assign new_base = ADDR_WIDTH'(led_tx_buf_id) * ADDR_WIDTH'(NLEDS);
    assign ack_now  = cyc && wb.wbm_ack;
    assign last_pix = (pix_idx == LAST_PIX);
    assign last_bit = bit_done && (bit_idx == LAST_BIT);

    // The top byte of a pixel word carries nothing for a GRB strip.
    assign unused_bits = ^wb.wbm_readdata[DATA_WIDTH-1:PIXEL_BITS];

    // load_word: a fresh pixel enters the shifter this cycle, either from the
    // holding register or straight off the bus when the read lands late.
    always_comb begin
        load_word = 1'b0;
        word      = wb.wbm_readdata[PIXEL_BITS-1:0];
        enc_start = 1'b0;
        enc_bit   = 1'b0;
        case (state)
            ST_FETCH: load_word = ack_now;
            ST_SHIFT: begin
                if ((last_bit || stall) && !last_pix) begin
                    if (hold_valid) begin
                        load_word = 1'b1;
                        word      = hold_reg;
                    end else begin
                        load_word = ack_now;
                    end
                end
            end
            default: ;
        endcase
        if (load_word) begin
            enc_start = 1'b1;
            enc_bit   = word[PIXEL_BITS-1];
        end else if (state == ST_SHIFT && bit_done && !last_bit) begin
            enc_start = 1'b1;
            enc_bit   = shift_reg[PIXEL_BITS-2];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            base       <= '0;
            pix_idx    <= '0;
            address    <= '0;
            cyc        <= 1'b0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            hold_reg   <= '0;
            hold_valid <= 1'b0;
            stall      <= 1'b0;
            done       <= 1'b0;
            latch_cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (ack_now) cyc <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // done still high means this is the completion cycle itself
                    if (led_tx && !done) begin
                        base       <= new_base;
                        address    <= new_base;
                        cyc        <= 1'b1;
                        pix_idx    <= '0;
                        bit_idx    <= '0;
                        hold_valid <= 1'b0;
                        stall      <= 1'b0;
                        state      <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (load_word) begin
                        shift_reg <= word;
                        bit_idx   <= '0;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (load_word) begin
                        shift_reg  <= word;
                        bit_idx    <= '0;
                        pix_idx    <= pix_idx + ADDR_WIDTH'(1);
                        stall      <= 1'b0;
                        hold_valid <= 1'b0;
                    end else if (bit_done) begin
                        if (!last_bit) begin
                            shift_reg <= {shift_reg[PIXEL_BITS-2:0], 1'b0};
                            bit_idx   <= bit_idx + 5'd1;
                        end else if (last_pix) begin
                            latch_cnt <= LATCH_LOAD;
                            state     <= ST_LATCH;
                        end else begin
                            stall <= 1'b1;
                        end
                    end
                    if (ack_now && !load_word) begin
                        hold_reg   <= wb.wbm_readdata[PIXEL_BITS-1:0];
                        hold_valid <= 1'b1;
                    end
                    // Prefetch the next pixel once per pixel, during its bit 0.
                    if (!cyc && !hold_valid && bit_idx == '0 && pix_idx < LAST_PIX) begin
                        cyc     <= 1'b1;
                        address <= base + pix_idx + ADDR_WIDTH'(1);
                    end
                end
                ST_LATCH: begin
                    if (latch_cnt == '0) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        latch_cnt <= latch_cnt - LCW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ws2812_bit_enc #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT)
    ) u_bit_enc (
        .clk      (clk),
        .reset    (reset),
        .start    (enc_start),
        .bit_in   (enc_bit),
        .led_dout (led_dout),
        .bit_done (bit_done)
    );

    assign wb.wbm_address   = address;
    assign wb.wbm_writedata = '0;
    assign wb.wbm_strobe    = cyc;
    assign wb.wbm_cycle     = cyc;
    assign wb.wbm_write     = 1'b0;
    assign led_tx_done      = done;

endmodule

// File: tb/tb_led_tx_engine.sv
module tb_led_tx_engine;
    localparam int NL = 2;
    localparam int T0 = 2;
    localparam int T1 = 4;
    localparam int TB = 6;
    localparam int TR = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] buf_id = '0;
    logic        led_tx = 1'b0;
    logic        done;
    logic        dout;

    always #5 clk = ~clk;

    led_tx_engine_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wb ();

    led_tx_engine #(
        .ADDR_WIDTH (32), .DATA_WIDTH (32), .NLEDS (NL),
        .T0H (T0), .T1H (T1), .TBIT (TB), .TRESET (TR)
    ) dut (
        .clk           (clk),
        .reset         (rst_n),
        .wb            (wb),
        .led_tx_buf_id (buf_id),
        .led_tx        (led_tx),
        .led_tx_done   (done),
        .led_dout      (dout)
    );

    // Wishbone slave: registered ack after an optional per-address delay.
    logic [31:0] mem [0:15];
    logic        s_ack = 1'b0;
    logic [31:0] s_rdata = '0;
    int          wcnt = 0;
    logic [31:0] slow_addr = 32'hFFFF_FFFF;
    int          slow_delay = 0;

    assign wb.wbm_ack      = s_ack;
    assign wb.wbm_readdata = s_ack ? s_rdata : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (!rst_n || s_ack) begin
            s_ack <= 1'b0;
            wcnt  <= 0;
        end else if (wb.wbm_cycle && wb.wbm_strobe) begin
            if (wcnt >= ((wb.wbm_address == slow_addr) ? slow_delay : 0)) begin
                s_ack   <= 1'b1;
                s_rdata <= mem[wb.wbm_address[3:0]];
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end

    typedef struct {
        logic [31:0] buf_id;
        logic [31:0] w0;
        logic [31:0] w1;
        int          slow;
        bit          busy;
        bit          quiet;
        int          a0;
        int          a1;
    } vec_t;

    vec_t vt [6];

    int n_vec = 0;
    int n_bad = 0;

    // monitor state, updated once per negedge by step()
    int cyc_no = 0;
    int pulses [$];
    int addrs [$];
    int run, low_run, max_low, done_cnt, last_high, done_at, first_ack, first_high;
    bit seen_high, wrote;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic mon_clear();
        pulses.delete();
        addrs.delete();
        run = 0; low_run = 0; max_low = 0; done_cnt = 0;
        last_high = -1; done_at = -1; first_ack = -1; first_high = -1;
        seen_high = 0; wrote = 0;
    endtask

    task automatic step();
        @(negedge clk);
        cyc_no++;
        if (wb.wbm_cycle && wb.wbm_strobe && wb.wbm_ack) begin
            addrs.push_back(int'(wb.wbm_address));
            if (first_ack < 0) first_ack = cyc_no;
        end
        if (wb.wbm_cycle && wb.wbm_write) wrote = 1;
        if (dout) begin
            if (seen_high && low_run > max_low) max_low = low_run;
            low_run = 0;
            seen_high = 1;
            run++;
            last_high = cyc_no;
            if (first_high < 0) first_high = cyc_no;
        end else begin
            if (run > 0) pulses.push_back(run);
            run = 0;
            low_run++;
        end
        if (done) begin
            done_cnt++;
            done_at = cyc_no;
        end
    endtask

    task automatic run_frame(input vec_t v);
        int exp_p [$];
        logic [31:0] w;
        int bad;
        mem[v.a0[3:0]] = v.w0;
        mem[v.a1[3:0]] = v.w1;
        buf_id     = v.buf_id;
        slow_addr  = (v.slow > 0) ? 32'(v.a1) : 32'hFFFF_FFFF;
        slow_delay = v.slow;

        step();
        mon_clear();
        led_tx = 1'b1;
        step();
        led_tx = 1'b0;
        chk("strobe_after_tx", longint'(wb.wbm_strobe), 1);
        chk("addr_on_first_strobe", longint'(wb.wbm_address), v.a0);

        for (int k = 0; k < 6000; k++) begin
            if (done_cnt > 0) break;
            if (v.busy && k == 60) led_tx = 1'b1;
            if (k == 61) led_tx = 1'b0;
            step();
        end
        chk("done_seen", done_cnt, 1);

        for (int p = 0; p < NL; p++) begin
            w = (p == 0) ? v.w0 : v.w1;
            for (int b = 23; b >= 0; b--) exp_p.push_back(w[b] ? T1 : T0);
        end
        chk("pulse_count", pulses.size(), exp_p.size());
        bad = 0;
        for (int i = 0; i < pulses.size() && i < exp_p.size(); i++)
            if (pulses[i] != exp_p[i]) bad++;
        chk("pulse_widths_bad", bad, 0);
        chk("read_count", addrs.size(), 2);
        if (addrs.size() >= 2) begin
            chk("read_addr0", addrs[0], v.a0);
            chk("read_addr1", addrs[1], v.a1);
        end
        chk("ack_to_first_high", first_high - first_ack, 1);
        chk("done_gap", done_at - last_high, TR + TB - exp_p[exp_p.size()-1] + 1);
        if (v.slow > 0) chk("stall_seen", longint'(max_low > TB - T0), 1);
        else            chk("no_stall", longint'(max_low <= TB - T0), 1);
        chk("no_write_cycle", longint'(wrote), 0);

        if (v.quiet) begin
            repeat (40) step();
            chk("single_done", done_cnt, 1);
            chk("single_frame", pulses.size(), exp_p.size());
        end
    endtask

    task automatic abort_seq();
        bit hit;
        buf_id = '0;
        slow_addr = 32'hFFFF_FFFF;
        slow_delay = 0;
        mem[0] = 32'h00A5_0000;
        mem[1] = 32'h00FF_FFFF;
        step();
        mon_clear();
        led_tx = 1'b1;
        step();
        led_tx = 1'b0;
        hit = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (dout && pulses.size() >= 3) begin
                hit = 1;
                break;
            end
        end
        chk("abort_reached_mid_bit", longint'(hit), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_outputs_zero",
            longint'({wb.wbm_cycle, wb.wbm_strobe, dout, done, wb.wbm_address}), 0);
        repeat (3) step();
        #2 rst_n = 1'b1;
        step();
        mon_clear();
        repeat (60) step();
        chk("abort_no_done", done_cnt, 0);
        chk("abort_line_quiet", pulses.size() + run, 0);
        chk("abort_bus_idle", longint'(wb.wbm_cycle), 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h00F0_F0F0 ^ 32'(i);
        //        buf_id  w0             w1             slow busy quiet a0  a1
        vt[0] = '{32'd0, 32'h00A5_0000, 32'h00FF_FFFF, 0,   0,   1,    0,  1};
        vt[1] = '{32'd3, 32'hFF00_F00F, 32'h7E3C_5A81, 0,   0,   1,    6,  7};
        vt[2] = '{32'd0, 32'h00A5_0000, 32'h00FF_FFFF, 200, 0,   1,    0,  1};
        vt[3] = '{32'd5, 32'h0000_0001, 32'h0080_0001, 0,   1,   1,    10, 11};
        vt[4] = '{32'd7, 32'h0012_3456, 32'h00AB_CDEF, 0,   0,   0,    14, 15};
        vt[5] = '{32'd1, 32'h0055_AA33, 32'h00C0_FFEE, 0,   0,   1,    2,  3};

        mon_clear();
        rst_n = 1'b0;
        repeat (3) step();
        chk("reset_outputs_zero",
            longint'({wb.wbm_cycle, wb.wbm_strobe, wb.wbm_write, dout, done,
                      wb.wbm_address, wb.wbm_writedata}), 0);
        #2 rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) run_frame(vt[i]);

        abort_seq();
        run_frame(vt[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
